// File: rtl/keypad_cmd_ctrl_pkg.sv
// Shared definitions for the keypad command sequencer: key codes, target
// encodings, FSM states and small key-classification helpers.
package keypad_cmd_ctrl_pkg;

  // Scanner key codes (0-9 are decimal digits)
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_CLEAR     = 4'd10;
  localparam logic [3:0] KEY_ENTER     = 4'd11;
  localparam logic [3:0] KEY_SEL_TEMP  = 4'd12;
  localparam logic [3:0] KEY_SEL_LIGHT = 4'd13;
  localparam logic [3:0] KEY_SEL_FEED  = 4'd14;
  localparam logic [3:0] KEY_CANCEL    = 4'd15;

  // Command target encodings
  localparam logic [1:0] TGT_TEMP  = 2'd0;
  localparam logic [1:0] TGT_LIGHT = 2'd1;
  localparam logic [1:0] TGT_FEED  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_ENTRY = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_DIGIT_MAX);
  endfunction

  function automatic logic is_select(input logic [3:0] code);
    return (code == KEY_SEL_TEMP) || (code == KEY_SEL_LIGHT) || (code == KEY_SEL_FEED);
  endfunction

  function automatic logic [1:0] select_target(input logic [3:0] code);
    logic [1:0] tgt;
    case (code)
      KEY_SEL_TEMP:  tgt = TGT_TEMP;
      KEY_SEL_LIGHT: tgt = TGT_LIGHT;
      KEY_SEL_FEED:  tgt = TGT_FEED;
      default:       tgt = TGT_TEMP;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/keypad_cmd_ctrl_key_event_sync.sv
// Key input stage: 2-FF synchroniser on the push level, rising-edge detect
// and code capture. One event per press; a key already held when reset is
// released must be let go before it can produce an event.
module key_event_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code_i,
  input  logic       key_push_i,
  output logic       evt_valid_o,
  output logic [3:0] evt_code_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic       evt_valid_q;
  logic [3:0] evt_code_q;
  logic       settled_s;
  logic       rise_s;

  // The chain reads 0 for two cycles after reset regardless of the key, so
  // arming waits until the synchronised level is trustworthy and low.
  assign settled_s = (settle_q == 2'd2);
  assign rise_s    = sync2_q & ~prev_q & armed_q;

  // Synchronise, detect the rising edge and register the event with its code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 4'd0;
    end else begin
      sync1_q <= key_push_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!settled_s) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settled_s && !sync2_q) begin
        armed_q <= 1'b1;
      end
      evt_valid_q <= rise_s;
      if (rise_s) begin
        evt_code_q <= key_code_i;
      end
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_code_o  = evt_code_q;

endmodule

// File: rtl/keypad_cmd_ctrl.sv
// Keypad command sequencer: select a target, type up to MAX_DIGITS decimal
// digits, press ENTER; the command is offered to the register bank with a
// valid/ready handshake. Stalled entries are aborted after TIMEOUT_CYC cycles.
module keypad_cmd_ctrl
  import keypad_cmd_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int VAL_W       = 10,
  parameter int MAX_VALUE   = 999,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_code,
  input  logic             key_push,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_target,
  output logic [VAL_W-1:0] cmd_value,
  output logic             busy,
  output logic             err,
  output logic [2:0]       digit_cnt
);

  // Accumulator has 4 spare bits so acc*10+digit cannot wrap before the range check
  localparam int ACC_W = VAL_W + 4;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ACC_W-1:0] VALUE_MAX = ACC_W'(MAX_VALUE);
  localparam logic [2:0]       DIG_MAX   = 3'(MAX_DIGITS);

  logic             evt_valid_s;
  logic [3:0]       evt_code_s;
  logic [ACC_W-1:0] acc_next_s;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [2:0]       digit_cnt_q;
  logic [1:0]       tgt_q;
  logic [TMR_W-1:0] timer_q;
  logic             cmd_valid_q;
  logic [1:0]       cmd_target_q;
  logic [VAL_W-1:0] cmd_value_q;
  logic             busy_q;
  logic             err_q;

  key_event_sync u_key_event_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_code_i  (key_code),
    .key_push_i  (key_push),
    .evt_valid_o (evt_valid_s),
    .evt_code_o  (evt_code_s)
  );

  assign acc_next_s = (acc_q << 3) + (acc_q << 1) + ACC_W'(evt_code_s);

  // Command FSM with accumulator, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      digit_cnt_q  <= 3'd0;
      tgt_q        <= 2'd0;
      timer_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_target_q <= 2'd0;
      cmd_value_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (evt_valid_s && is_select(evt_code_s)) begin
            tgt_q       <= select_target(evt_code_s);
            acc_q       <= '0;
            digit_cnt_q <= 3'd0;
            busy_q      <= 1'b1;
            state_q     <= ST_SEL;
          end
        end

        ST_SEL: begin
          if (timer_q == TMO_LAST) begin
            // Timeout wins over a key event arriving in the same cycle
            err_q       <= 1'b1;
            acc_q       <= '0;
            digit_cnt_q <= 3'd0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (evt_valid_s) begin
            timer_q <= '0;
            if (is_digit(evt_code_s)) begin
              acc_q       <= ACC_W'(evt_code_s);
              digit_cnt_q <= 3'd1;
              state_q     <= ST_ENTRY;
            end else if (is_select(evt_code_s)) begin
              tgt_q <= select_target(evt_code_s);
            end else if (evt_code_s == KEY_ENTER) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (evt_code_s == KEY_CANCEL) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        ST_ENTRY: begin
          if (timer_q == TMO_LAST) begin
            err_q       <= 1'b1;
            acc_q       <= '0;
            digit_cnt_q <= 3'd0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (evt_valid_s) begin
            timer_q <= '0;
            if (is_digit(evt_code_s)) begin
              // Digits beyond MAX_DIGITS are silently dropped
              if (digit_cnt_q < DIG_MAX) begin
                acc_q       <= acc_next_s;
                digit_cnt_q <= digit_cnt_q + 3'd1;
              end
            end else if (evt_code_s == KEY_CLEAR) begin
              acc_q       <= '0;
              digit_cnt_q <= 3'd0;
              state_q     <= ST_SEL;
            end else if (evt_code_s == KEY_CANCEL) begin
              acc_q       <= '0;
              digit_cnt_q <= 3'd0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else if (evt_code_s == KEY_ENTER) begin
              if (acc_q > VALUE_MAX) begin
                err_q       <= 1'b1;
                acc_q       <= '0;
                digit_cnt_q <= 3'd0;
                state_q     <= ST_SEL;
              end else begin
                cmd_value_q  <= acc_q[VAL_W-1:0];
                cmd_target_q <= tgt_q;
                cmd_valid_q  <= 1'b1;
                state_q      <= ST_WAIT;
              end
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        ST_WAIT: begin
          // Key events are dropped here; command held until accepted
          timer_q <= '0;
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            acc_q       <= '0;
            digit_cnt_q <= 3'd0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          acc_q       <= '0;
          digit_cnt_q <= 3'd0;
          timer_q     <= '0;
          cmd_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_target = cmd_target_q;
  assign cmd_value  = cmd_value_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_keypad_cmd_ctrl.sv
// Directed bench for keypad_cmd_ctrl. Unit A uses MAX_VALUE=999, unit B
// MAX_VALUE=500; both use TIMEOUT_CYC=100 and share key_code and rst_n.
module tb_keypad_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       push_a, push_b, ready_a, ready_b;
  logic       valid_a, valid_b, busy_a, busy_b, err_a, err_b;
  logic [1:0] tgt_a, tgt_b;
  logic [9:0] val_a, val_b;
  logic [2:0] dcnt_a, dcnt_b;

  int checks = 0;
  int failures = 0;
  int hs_a = 0, hs_b = 0, errs_a = 0, errs_b = 0;
  logic [1:0] last_tgt_a = 2'd0, last_tgt_b = 2'd0;
  logic [9:0] last_val_a = 10'd0, last_val_b = 10'd0;
  int bad;
  int h0, e0;

  always #5 clk = ~clk;

  keypad_cmd_ctrl #(.MAX_DIGITS(3), .VAL_W(10), .MAX_VALUE(999), .TIMEOUT_CYC(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_push(push_a), .cmd_ready(ready_a),
    .cmd_valid(valid_a), .cmd_target(tgt_a), .cmd_value(val_a), .busy(busy_a),
    .err(err_a), .digit_cnt(dcnt_a));

  keypad_cmd_ctrl #(.MAX_DIGITS(3), .VAL_W(10), .MAX_VALUE(500), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_push(push_b), .cmd_ready(ready_b),
    .cmd_valid(valid_b), .cmd_target(tgt_b), .cmd_value(val_b), .busy(busy_b),
    .err(err_b), .digit_cnt(dcnt_b));

  // Scoreboard: count accepted handshakes and err pulses, remember last command
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      hs_a <= hs_a + 1;
      last_tgt_a <= tgt_a;
      last_val_a <= val_a;
    end
    if (valid_b && ready_b) begin
      hs_b <= hs_b + 1;
      last_tgt_b <= tgt_b;
      last_val_b <= val_b;
    end
    if (err_a) errs_a <= errs_a + 1;
    if (err_b) errs_b <= errs_b + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit unit_b, input logic [3:0] code);
    key_code = code;
    if (unit_b) push_b = 1'b1;
    else push_a = 1'b1;
    tick(20);
    push_a = 1'b0;
    push_b = 1'b0;
    tick(20);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; key_code = 4'd0; push_a = 1'b0; push_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    tick(5);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    check_eq("rst_value", 32'(val_a), 32'd0);
    check_eq("rst_dcnt", 32'(dcnt_a), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Test 1: 12,2,6,11 with ready high, ENTER latency of 4 cycles
    ready_a = 1'b1;
    h0 = hs_a; e0 = errs_a;
    press(1'b0, 4'd12); press(1'b0, 4'd2); press(1'b0, 4'd6);
    key_code = 4'd11; push_a = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t1_lat_early", 32'(valid_a), 32'd0);
    @(negedge clk);
    check_eq("t1_lat_valid", 32'(valid_a), 32'd1);
    check_eq("t1_target", 32'(tgt_a), 32'd0);
    check_eq("t1_value", 32'(val_a), 32'd26);
    @(negedge clk);
    check_eq("t1_valid_drop", 32'(valid_a), 32'd0);
    tick(14);
    push_a = 1'b0;
    tick(20);
    check_eq("t1_hs", 32'(hs_a - h0), 32'd1);
    check_eq("t1_hs_value", 32'(last_val_a), 32'd26);
    check_eq("t1_no_err", 32'(errs_a - e0), 32'd0);
    check_eq("t1_busy", 32'(busy_a), 32'd0);

    // Test 2: 13,9,9,9,9,11 held without ready; keys in WAIT dropped
    ready_a = 1'b0;
    h0 = hs_a;
    press(1'b0, 4'd13); press(1'b0, 4'd9); press(1'b0, 4'd9); press(1'b0, 4'd9); press(1'b0, 4'd9);
    check_eq("t2_dcnt", 32'(dcnt_a), 32'd3);
    press(1'b0, 4'd11);
    check_eq("t2_valid", 32'(valid_a), 32'd1);
    check_eq("t2_value", 32'(val_a), 32'd999);
    check_eq("t2_target", 32'(tgt_a), 32'd1);
    bad = 0;
    fork
      begin
        press(1'b0, 4'd12);
        press(1'b0, 4'd5);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (valid_a !== 1'b1 || val_a !== 10'd999 || tgt_a !== 2'd1) bad++;
        end
      end
    join
    check_eq("t2_stable", 32'(bad), 32'd0);
    check_eq("t2_no_hs_yet", 32'(hs_a - h0), 32'd0);
    ready_a = 1'b1;
    tick(2);
    check_eq("t2_hs", 32'(hs_a - h0), 32'd1);
    check_eq("t2_hs_value", 32'(last_val_a), 32'd999);
    check_eq("t2_hs_target", 32'(last_tgt_a), 32'd1);
    check_eq("t2_busy", 32'(busy_a), 32'd0);
    tick(20);
    check_eq("t2_single_cmd", 32'(hs_a - h0), 32'd1);

    // Test 3 (unit B, MAX_VALUE=500): 14,7,0,0,11 rejected, then 1,2,11
    ready_b = 1'b1;
    h0 = hs_b; e0 = errs_b;
    press(1'b1, 4'd14); press(1'b1, 4'd7); press(1'b1, 4'd0); press(1'b1, 4'd0); press(1'b1, 4'd11);
    check_eq("t3_err", 32'(errs_b - e0), 32'd1);
    check_eq("t3_no_hs", 32'(hs_b - h0), 32'd0);
    check_eq("t3_busy_sel", 32'(busy_b), 32'd1);
    check_eq("t3_dcnt", 32'(dcnt_b), 32'd0);
    press(1'b1, 4'd1); press(1'b1, 4'd2); press(1'b1, 4'd11);
    check_eq("t3_hs", 32'(hs_b - h0), 32'd1);
    check_eq("t3_target", 32'(last_tgt_b), 32'd2);
    check_eq("t3_value", 32'(last_val_b), 32'd12);
    check_eq("t3_err_once", 32'(errs_b - e0), 32'd1);

    // Test 4: 12,5 then idle until timeout; a later ENTER is ignored
    h0 = hs_a; e0 = errs_a;
    press(1'b0, 4'd12); press(1'b0, 4'd5);
    check_eq("t4_pre_err", 32'(errs_a - e0), 32'd0);
    check_eq("t4_pre_busy", 32'(busy_a), 32'd1);
    check_eq("t4_pre_dcnt", 32'(dcnt_a), 32'd1);
    tick(80);
    check_eq("t4_tmo_err", 32'(errs_a - e0), 32'd1);
    check_eq("t4_tmo_busy", 32'(busy_a), 32'd0);
    check_eq("t4_tmo_dcnt", 32'(dcnt_a), 32'd0);
    press(1'b0, 4'd11);
    check_eq("t4_enter_busy", 32'(busy_a), 32'd0);
    check_eq("t4_enter_err", 32'(errs_a - e0), 32'd1);
    check_eq("t4_enter_hs", 32'(hs_a - h0), 32'd0);

    // Test 5: long hold is one event; CLEAR restarts entry; CANCEL aborts
    e0 = errs_a;
    key_code = 4'd12; push_a = 1'b1;
    tick(50);
    check_eq("t5_hold_busy", 32'(busy_a), 32'd1);
    tick(450);
    check_eq("t5_hold_tmo", 32'(busy_a), 32'd0);
    check_eq("t5_hold_err", 32'(errs_a - e0), 32'd1);
    push_a = 1'b0;
    tick(20);
    check_eq("t5_rel_busy", 32'(busy_a), 32'd0);
    h0 = hs_a;
    press(1'b0, 4'd12); press(1'b0, 4'd3); press(1'b0, 4'd10); press(1'b0, 4'd4); press(1'b0, 4'd11);
    check_eq("t5_clr_hs", 32'(hs_a - h0), 32'd1);
    check_eq("t5_clr_value", 32'(last_val_a), 32'd4);
    check_eq("t5_clr_target", 32'(last_tgt_a), 32'd0);
    press(1'b0, 4'd12); press(1'b0, 4'd15);
    check_eq("t5_cancel_busy", 32'(busy_a), 32'd0);
    check_eq("t5_cancel_hs", 32'(hs_a - h0), 32'd1);
    check_eq("t5_cancel_err", 32'(errs_a - e0), 32'd1);

    // Test 6: asynchronous reset in WAIT and in ENTRY; held key ignored after release
    ready_a = 1'b0;
    press(1'b0, 4'd12); press(1'b0, 4'd8); press(1'b0, 4'd11);
    check_eq("t6_wait_valid", 32'(valid_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(valid_a), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_a), 32'd0);
    check_eq("t6_rst_value", 32'(val_a), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    press(1'b0, 4'd13); press(1'b0, 4'd4);
    check_eq("t6_entry_busy", 32'(busy_a), 32'd1);
    check_eq("t6_entry_dcnt", 32'(dcnt_a), 32'd1);
    key_code = 4'd12; push_a = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst2_busy", 32'(busy_a), 32'd0);
    check_eq("t6_rst2_dcnt", 32'(dcnt_a), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check_eq("t6_held_no_evt", 32'(busy_a), 32'd0);
    push_a = 1'b0;
    tick(20);
    press(1'b0, 4'd12);
    check_eq("t6_new_press", 32'(busy_a), 32'd1);
    press(1'b0, 4'd15);
    check_eq("t6_final_idle", 32'(busy_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
